// File: rtl/fwd_select_reg.sv
// Purpose : registered operand-forwarding select for the EX stage. It picks one
//           of NUM_INPUTS sources and feeds it to the ALU directly and through a
//           pipeline register that has valid, stall and flush control.
// Latency : out_comb is combinational (0 cycles); out_data follows 1 cycle after an accepting edge.
// Backpr. : stall holds out_data and out_valid; flush kills the stage and takes priority over stall.
//
// Optional feature macro: FWD_SEL_ERR_CNT_EN
//   defined   -> err_cnt counts out-of-range accepts and saturates at 8'hFF
//   undefined -> err_cnt is tied to 8'h00 and no counter is built
//
// Ports:
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_data    flattened sources; source k is in_data[k*WIDTH +: WIDTH]
//   sel        source index; any value >= NUM_INPUTS selects zero
//   in_valid   the current operand is real (not a bubble)
//   stall      hold the registered stage
//   flush      kill the registered stage
//   out_comb   combinational selected value (not gated by valid, stall or reset)
//   out_data   registered selected value
//   out_valid  out_data holds a live operand
//   sel_err    sticky flag: an out-of-range sel was accepted (cleared only by reset)
//   err_cnt    number of out-of-range accepts (feature-dependent)

module fwd_select_reg #(
  parameter int WIDTH      = 32,
  parameter int NUM_INPUTS = 3,
  // Derived from NUM_INPUTS; never set by the instantiating module. It is at least 1 bit.
  localparam int SEL_W     = (NUM_INPUTS > 1) ? $clog2(NUM_INPUTS) : 1
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic [NUM_INPUTS*WIDTH-1:0] in_data,
  input  logic [SEL_W-1:0]            sel,
  input  logic                        in_valid,
  input  logic                        stall,
  input  logic                        flush,
  output logic [WIDTH-1:0]            out_comb,
  output logic [WIDTH-1:0]            out_data,
  output logic                        out_valid,
  output logic                        sel_err,
  output logic [7:0]                  err_cnt
);

  // Widen sel to 32 bits so it can be compared against integer bounds
  // without width mismatches for any SEL_W.
  logic [31:0] sel_ext;
  logic        sel_oor;
  logic        accept;

  assign sel_ext = 32'(sel);

  // When NUM_INPUTS is a power of two this comparison is never true,
  // so sel_err and err_cnt stay at zero.
  assign sel_oor = (sel_ext >= 32'(NUM_INPUTS));

  // An operand is taken into the stage only when it is not flushed,
  // not stalled, and marked valid.
  assign accept  = !flush && !stall && in_valid;

  // Source mux. The default of zero handles out-of-range selects: no
  // branch of the loop matches them.
  always_comb begin
    out_comb = '0;
    for (int k = 0; k < NUM_INPUTS; k++) begin
      if (sel_ext == 32'(k)) begin
        out_comb = in_data[k*WIDTH +: WIDTH];
      end
    end
  end

  // Stage register. The priority order is reset, then flush, then stall,
  // then load. A bubble (in_valid=0) clears out_valid but keeps the old
  // data, so the stage does not toggle out_data for nothing.
  always_ff @(posedge clk) begin
    if (reset) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (flush) begin
      out_data  <= '0;
      out_valid <= 1'b0;
    end else if (!stall) begin
      if (in_valid) begin
        out_data  <= out_comb;
        out_valid <= 1'b1;
      end else begin
        out_valid <= 1'b0;
      end
    end
  end

  // Sticky error flag. Flush and stall block an accept but never clear the flag.
  always_ff @(posedge clk) begin
    if (reset) begin
      sel_err <= 1'b0;
    end else if (accept && sel_oor) begin
      sel_err <= 1'b1;
    end
  end

`ifdef FWD_SEL_ERR_CNT_EN
  // Saturating count of out-of-range accepts. It stops at 8'hFF and
  // does not wrap.
  always_ff @(posedge clk) begin
    if (reset) begin
      err_cnt <= 8'h00;
    end else if (accept && sel_oor && (err_cnt != 8'hFF)) begin
      err_cnt <= err_cnt + 8'h01;
    end
  end
`else
  assign err_cnt = 8'h00;
`endif

endmodule

// File: doc/fwd_select_reg.md
Name: fwd_select_reg

Overview:
- Parametrised, registered operand-forwarding select stage for the pipelined MIPS datapath; generalises the fixed 3-input 32-bit forwarding mux to NUM_INPUTS sources of WIDTH bits.
- Sits between the ID/EX register and the ALU operand inputs.
- Provides a same-cycle combinational result for the ALU and a registered copy with valid, stall and flush control for the next pipeline stage.
- Out-of-range selects yield zero.

Parameters:
- WIDTH, 32, data width of each source and of the outputs.
- NUM_INPUTS, 3, number of selectable sources (>=2).
- SEL_W, $clog2(NUM_INPUTS) (min 1), selector width; derived, not overridden.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  synchronous, active-high reset.
- in_data  input  NUM_INPUTS*WIDTH  flattened sources; source k occupies bits [k*WIDTH +: WIDTH].
- sel  input  SEL_W  source index.
- in_valid  input  1  current operand is real (not a bubble).
- stall  input  1  hold the registered stage.
- flush  input  1  kill the registered stage.
- out_comb  output  WIDTH  combinational selected value.
- out_data  output  WIDTH  registered selected value.
- out_valid  output  1  out_data holds a live operand.
- sel_err  output  1  sticky: an out-of-range sel was accepted.
- err_cnt  output  8  count of out-of-range accepts (feature-dependent).

Behaviour:
- Clock and reset: one clock, clk; reset is synchronous and active-high.
- Reset: out_data=0, out_valid=0, sel_err=0, err_cnt=0. Reset overrides flush, stall and in_valid in the same cycle.
- out_comb, purely combinational, zero latency:
  - sel < NUM_INPUTS: in_data[sel*WIDTH +: WIDTH].
  - else: 0.
  - Not gated by in_valid, stall or reset.
- Registered stage, updates on the rising edge. Priority: reset > flush > stall > load.
  - flush=1: out_data<=0, out_valid<=0.
  - flush=0, stall=1: out_data and out_valid hold.
  - flush=0, stall=0, in_valid=1 (accept): out_data<=out_comb, out_valid<=1.
  - flush=0, stall=0, in_valid=0: out_valid<=0; out_data holds its previous value.
- Latency: exactly 1 cycle from an accepting edge to out_data.
- sel_err: set on any accept with sel >= NUM_INPUTS. Cleared only by reset; flush and stall do not clear it.
- When NUM_INPUTS is a power of two, no sel value is out of range, so sel_err stays 0.
- Stall with flush in the same cycle: flush wins.
- Stall held for multiple cycles: output holds indefinitely, with no change to sel_err or err_cnt.
- No internal state machine beyond the stage register and the error tracking.

Optional Feature:
- Macro: FWD_SEL_ERR_CNT_EN.
- Defined:
  - err_cnt increments by 1 on each accept with out-of-range sel.
  - Saturates at 8'hFF; no wrap.
  - Reset to 0; unaffected by flush and stall.
- Undefined: err_cnt is tied to 8'h00 and no counter logic is built; sel_err behaviour is unchanged.

Test Plan:
- Default params: sources 0x11111111 / 0x22222222 / 0x33333333, sel=1, in_valid=1 -> out_comb=0x22222222 in the same cycle; out_data=0x22222222 and out_valid=1 after 1 edge.
- sel=3 (out of range), in_valid=1 -> out_comb=0; out_data=0, out_valid=1, sel_err=1 next edge; err_cnt=1 with FWD_SEL_ERR_CNT_EN defined, 0 without.
- Load 0x33333333, then stall=1 for 3 cycles while sel and sources change -> out_data stays 0x33333333 and out_valid stays 1; then stall=0, sel=0 -> 0x11111111 next edge.
- stall=1 and flush=1 in the same cycle with out_valid=1 -> next edge out_data=0, out_valid=0.
- With FWD_SEL_ERR_CNT_EN defined, 300 consecutive accepts with sel=3 -> err_cnt=0xFF (saturated). Then assert reset with flush=1 -> all outputs 0 next edge.
- NUM_INPUTS=4, WIDTH=8: all sel values 0..3 -> the correct byte is selected and sel_err stays 0. Then in_valid=0 -> out_valid=0 and out_data holds.
